// File: rtl/dcache_preload_master.sv
// -----------------------------------------------------------------------------
// dcache_preload_master
//
// Host-side driver for the pipeline's data-memory preload port. A host pushes a
// word stream (base address, word count, then the data words); each data word
// becomes one single-cycle memory write at consecutive word addresses, and a
// one-cycle `done` pulse reports the end of the burst.
//
// Optional feature (compile-time macro): DCACHE_PRELOAD_VERIFY_EN
//   When defined, the loaded region is read back through `output_check` after
//   the last write. The XOR of all written words is compared with the XOR of
//   all read-back words, and the sticky `err` flag is set on a difference.
//   When undefined, LOAD goes straight to DONE and `err` is tied low.
//
// Handshake: a stream word transfers on a rising edge where s_valid && s_ready.
// s_ready is a registered function of the FSM state only, so there is no
// combinational path from s_valid to s_ready. The host may hold s_valid low
// for any number of cycles; nothing is lost while it stalls.
//
// Ports
//   clk           in   core clock, rising edge
//   arst_n        in   asynchronous active-low reset
//   s_valid       in   host stream word valid
//   s_data        in   host stream word [DPW]
//   s_ready       out  block accepts s_data this cycle (high in IDLE/CNT/LOAD)
//   data_en       out  memory write strobe, one cycle per data word
//   input_addr    out  byte address for write or readback [DPW]
//   input_data    out  write data [DPW]
//   output_check  in   combinational memory read data at input_addr [DPW]
//   busy          out  high whenever the FSM is outside IDLE
//   done          out  one-cycle pulse at the end of each burst
//   err           out  sticky verify mismatch, cleared by the next base word
//   dbg_state     out  current FSM state encoding (observation only)
// -----------------------------------------------------------------------------
module dcache_preload_master #(
  parameter int DPW   = 32,
  parameter int CNT_W = 8
) (
  input  logic           clk,
  input  logic           arst_n,
  input  logic           s_valid,
  input  logic [DPW-1:0] s_data,
  output logic           s_ready,
  output logic           data_en,
  output logic [DPW-1:0] input_addr,
  output logic [DPW-1:0] input_data,
  input  logic [DPW-1:0] output_check,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [2:0]     dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CNT    = 3'd1,
    S_LOAD   = 3'd2,
    S_VERIFY = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [DPW-1:0]   base_q;
  logic [CNT_W-1:0] n_q;
  logic [CNT_W-1:0] idx_q;
  logic             s_ready_q;
  logic             data_en_q;
  logic [DPW-1:0]   input_addr_q;
  logic [DPW-1:0]   input_data_q;
  logic             busy_q;
  logic             done_q;
  logic             hs;
  logic             last_word;

`ifdef DCACHE_PRELOAD_VERIFY_EN
  logic [CNT_W-1:0] vidx_q;
  logic [DPW-1:0]   wr_xor_q;
  logic [DPW-1:0]   rd_xor_q;
  logic             err_q;
`endif

  // Byte offset of word i, zero-extended to the address width.
  function automatic logic [DPW-1:0] word_offset(input logic [CNT_W-1:0] i);
    logic [DPW-1:0] off;
    off = '0;
    off[CNT_W+1:0] = {i, 2'b00};
    return off;
  endfunction

  assign hs        = s_valid && s_ready_q;
  assign last_word = (idx_q == (n_q - CNT_W'(1)));

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (hs) state_d = S_CNT;
      end
      S_CNT: begin
        if (hs) begin
          // A zero count skips both the writes and the readback.
          if (s_data[CNT_W-1:0] == '0) state_d = S_DONE;
          else                         state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (hs && last_word) begin
`ifdef DCACHE_PRELOAD_VERIFY_EN
          state_d = S_VERIFY;
`else
          state_d = S_DONE;
`endif
        end
      end
      S_VERIFY: begin
`ifdef DCACHE_PRELOAD_VERIFY_EN
        // One readback address is issued per cycle; the last one is issued
        // when vidx_q reaches n-1, and its sample is taken in DONE.
        if (vidx_q == (n_q - CNT_W'(1))) state_d = S_DONE;
`else
        state_d = S_DONE;
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      n_q          <= '0;
      idx_q        <= '0;
      s_ready_q    <= 1'b1;
      data_en_q    <= 1'b0;
      input_addr_q <= '0;
      input_data_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef DCACHE_PRELOAD_VERIFY_EN
      vidx_q       <= '0;
      wr_xor_q     <= '0;
      rd_xor_q     <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      // s_ready and busy are registered copies of the next state, so they
      // line up exactly with state_q in every cycle.
      s_ready_q <= (state_d == S_IDLE) || (state_d == S_CNT) || (state_d == S_LOAD);
      busy_q    <= (state_d != S_IDLE);
      data_en_q <= 1'b0;
      done_q    <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (hs) begin
            // Byte address is forced word-aligned.
            base_q <= {s_data[DPW-1:2], 2'b00};
            n_q    <= '0;
            idx_q  <= '0;
`ifdef DCACHE_PRELOAD_VERIFY_EN
            vidx_q   <= '0;
            wr_xor_q <= '0;
            rd_xor_q <= '0;
            err_q    <= 1'b0;
`endif
          end
        end

        S_CNT: begin
          if (hs) n_q <= s_data[CNT_W-1:0];
        end

        S_LOAD: begin
          if (hs) begin
            data_en_q    <= 1'b1;
            input_addr_q <= base_q + word_offset(idx_q);
            input_data_q <= s_data;
            idx_q        <= idx_q + CNT_W'(1);
`ifdef DCACHE_PRELOAD_VERIFY_EN
            wr_xor_q     <= wr_xor_q ^ s_data;
`endif
          end
        end

`ifdef DCACHE_PRELOAD_VERIFY_EN
        S_VERIFY: begin
          // input_addr is registered, so the sample taken at this edge belongs
          // to the address issued one edge earlier (skipped on the first edge,
          // when input_addr still holds the last write address).
          input_addr_q <= base_q + word_offset(vidx_q);
          if (vidx_q != '0) rd_xor_q <= rd_xor_q ^ output_check;
          vidx_q <= vidx_q + CNT_W'(1);
        end
`endif

        S_DONE: begin
          done_q <= 1'b1;
`ifdef DCACHE_PRELOAD_VERIFY_EN
          // Fold in the sample for the final readback address and compare.
          // A zero-count burst performs no readback and leaves err alone.
          if (n_q != '0) err_q <= ((rd_xor_q ^ output_check) != wr_xor_q);
`endif
        end

        default: begin
        end
      endcase
    end
  end

  assign s_ready    = s_ready_q;
  assign data_en    = data_en_q;
  assign input_addr = input_addr_q;
  assign input_data = input_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign dbg_state  = state_q;

`ifdef DCACHE_PRELOAD_VERIFY_EN
  assign err = err_q;
`else
  // Readback data has no consumer without the verify feature.
  logic unused_check;
  assign unused_check = ^output_check;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dcache_preload_master.sv
`timescale 1ns/1ps
module tb_dcache_preload_master;

  localparam int DPW   = 32;
  localparam int CNT_W = 8;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic             clk = 1'b0;
  logic             arst_n = 1'b0;
  logic             s_valid = 1'b0;
  logic [DPW-1:0]   s_data = '0;
  logic [DPW-1:0]   output_check = '0;
  logic             s_ready;
  logic             data_en;
  logic [DPW-1:0]   input_addr;
  logic [DPW-1:0]   input_data;
  logic             busy;
  logic             done;
  logic             err;
  logic [2:0]       dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  dcache_preload_master #(.DPW(DPW), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .data_en      (data_en),
    .input_addr   (input_addr),
    .input_data   (input_data),
    .output_check (output_check),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .dbg_state    (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Memory model and output monitor (sampled on the falling edge)
  // ---------------------------------------------------------------------------
  logic [DPW-1:0] mem [logic [DPW-1:0]];
  logic [DPW-1:0] corrupt_addr = 32'h0000_0001;  // odd: never a word address
  logic [63:0]    wr_q[$];
  int             wr_cyc_q[$];
  logic [DPW-1:0] addr_at [int];
  int             done_cnt = 0;
  int             done_cyc = 0;
  logic           err_at_done = 1'b0;

  always @(negedge clk) begin
    addr_at[cyc] = input_addr;
    if (data_en) begin
      mem[input_addr] = input_data;
      wr_q.push_back({input_addr, input_data});
      wr_cyc_q.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      err_at_done = err;
    end
    if (mem.exists(input_addr))
      output_check = mem[input_addr] ^ ((input_addr == corrupt_addr) ? 32'h0000_0100 : 32'h0);
    else
      output_check = '0;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [63:0] exp_q[$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drain_writes(input string name);
    logic [63:0] e;
    logic [63:0] a;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (wr_q.size() > 0) a = wr_q.pop_front();
      else                 a = 'x;
      chk(name, a, e);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (called on a falling edge, return on a falling edge)
  // ---------------------------------------------------------------------------
  int last_hs = 0;

  task automatic send(input logic [DPW-1:0] d);
    int budget;
    budget = 100;
    s_valid = 1'b1;
    s_data  = d;
    while (!s_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("s_ready_before_hs", 64'(s_ready), 64'(1));
    @(posedge clk);
    last_hs = cyc;
    @(negedge clk);
  endtask

  task automatic idle(input int k);
    s_valid = 1'b0;
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_done(input int prev);
    int budget;
    budget = 400;
    while (done_cnt == prev && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    repeat (3) @(negedge clk);
    chk("done_pulses", 64'(done_cnt - prev), 64'(1));
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_s_ready"},    64'(s_ready),    64'(1));
    chk({tag, "_data_en"},    64'(data_en),    64'(0));
    chk({tag, "_input_addr"}, 64'(input_addr), 64'(0));
    chk({tag, "_input_data"}, 64'(input_data), 64'(0));
    chk({tag, "_busy"},       64'(busy),       64'(0));
    chk({tag, "_done"},       64'(done),       64'(0));
    chk({tag, "_err"},        64'(err),        64'(0));
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [31:0]      base;
    logic [31:0]      cnt_word;
    logic [7:0]       n;
    logic [7:0]       gap;
    logic [3:0][31:0] w;
    logic [3:0][31:0] ea;
  } vec_t;

  localparam int NV = 6;
  vec_t vt [NV];

  task automatic set_vec(input int i, input logic [31:0] b, input logic [31:0] c,
                         input int n, input int g,
                         input logic [31:0] w0, input logic [31:0] w1,
                         input logic [31:0] w2, input logic [31:0] w3,
                         input logic [31:0] e0, input logic [31:0] e1,
                         input logic [31:0] e2, input logic [31:0] e3);
    vt[i].base     = b;
    vt[i].cnt_word = c;
    vt[i].n        = 8'(n);
    vt[i].gap      = 8'(g);
    vt[i].w[0] = w0; vt[i].w[1] = w1; vt[i].w[2] = w2; vt[i].w[3] = w3;
    vt[i].ea[0] = e0; vt[i].ea[1] = e1; vt[i].ea[2] = e2; vt[i].ea[3] = e3;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pd;
    int first_hs;
    int n;
    int exp_lat;

    //          idx base          count         n  gap  words                                              expected addresses
    set_vec(0, 32'h0000_0100, 32'd3,        3, 0, 32'hAAAA_0001, 32'hAAAA_0002, 32'hAAAA_0003, 32'h0,
                                                  32'h0000_0100, 32'h0000_0104, 32'h0000_0108, 32'h0);
    set_vec(1, 32'h0000_0203, 32'd0,        0, 0, 32'h0, 32'h0, 32'h0, 32'h0,
                                                  32'h0, 32'h0, 32'h0, 32'h0);
    set_vec(2, 32'h0000_0203, 32'd1,        1, 0, 32'h1234_5678, 32'h0, 32'h0, 32'h0,
                                                  32'h0000_0200, 32'h0, 32'h0, 32'h0);
    set_vec(3, 32'h0000_0300, 32'd2,        2, 5, 32'h5A5A_0000, 32'h5A5A_0001, 32'h0, 32'h0,
                                                  32'h0000_0300, 32'h0000_0304, 32'h0, 32'h0);
    set_vec(4, 32'hFFFF_FFF8, 32'd4,        4, 0, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444,
                                                  32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004);
    set_vec(5, 32'h0000_1001, 32'hFFFF_FF02, 2, 0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 32'h0, 32'h0,
                                                  32'h0000_1000, 32'h0000_1004, 32'h0, 32'h0);

    // Reset state
    repeat (3) @(negedge clk);
    chk_reset_values("reset");
    arst_n = 1'b1;
    @(negedge clk);

    // Table-driven bursts
    for (int v = 0; v < NV; v++) begin
      n = int'(vt[v].n);
      first_hs = 0;
      wr_q.delete();
      wr_cyc_q.delete();
      pd = done_cnt;
      send(vt[v].base);
      chk("busy_after_base", 64'(busy), 64'(1));
      send(vt[v].cnt_word);
      for (int k = 0; k < n; k++) begin
        if (k > 0 && vt[v].gap != 0) idle(int'(vt[v].gap));
        send(vt[v].w[k]);
        if (k == 0) first_hs = last_hs;
      end
      s_valid = 1'b0;
      wait_done(pd);

`ifdef DCACHE_PRELOAD_VERIFY_EN
      exp_lat = (n == 0) ? 2 : n + 2;
`else
      exp_lat = 2;
`endif
      chk("done_latency", 64'(done_cyc - last_hs), 64'(exp_lat));
      chk("err_at_done", 64'(err_at_done), 64'(0));
      chk("busy_after_done", 64'(busy), 64'(0));
      chk("write_count", 64'(wr_q.size()), 64'(n));
      if (wr_cyc_q.size() > 0)
        chk("first_write_latency", 64'(wr_cyc_q[0] - first_hs), 64'(1));
      if (wr_cyc_q.size() > 1)
        chk("write_spacing", 64'(wr_cyc_q[1] - wr_cyc_q[0]), 64'(int'(vt[v].gap) + 1));
`ifdef DCACHE_PRELOAD_VERIFY_EN
      for (int j = 0; j < n; j++)
        chk("readback_addr", 64'(addr_at[last_hs + 2 + j]), 64'(vt[v].ea[j]));
`endif
      for (int k = 0; k < n; k++) exp_q.push_back({vt[v].ea[k], vt[v].w[k]});
      drain_writes("write_addr_data");
    end

`ifdef DCACHE_PRELOAD_VERIFY_EN
    // Verify mismatch: the memory returns a corrupted word at 0x104
    corrupt_addr = 32'h0000_0104;
    wr_q.delete();
    wr_cyc_q.delete();
    pd = done_cnt;
    send(32'h0000_0100);
    send(32'd3);
    send(32'h0F0F_0001);
    send(32'h0F0F_0002);
    send(32'h0F0F_0003);
    s_valid = 1'b0;
    wait_done(pd);
    chk("verify_err_at_done", 64'(err_at_done), 64'(1));
    for (int j = 0; j < 3; j++)
      chk("verify_sweep_addr", 64'(addr_at[last_hs + 2 + j]), 64'(32'h100 + 4 * j));
    chk("err_sticky", 64'(err), 64'(1));
    corrupt_addr = 32'h0000_0001;
    pd = done_cnt;
    send(32'h0000_0400);
    chk("err_cleared_by_base", 64'(err), 64'(0));
    send(32'd0);
    s_valid = 1'b0;
    wait_done(pd);
    wr_q.delete();
    wr_cyc_q.delete();
`endif

    // Reset in the middle of a 4-word burst
    send(32'h0000_0500);
    send(32'd4);
    send(32'h7777_0000);
    send(32'h7777_0001);
    chk("mid_burst_data_en", 64'(data_en), 64'(1));
    chk("mid_burst_addr", 64'(input_addr), 64'(32'h0000_0504));
    #1;
    arst_n = 1'b0;
    s_valid = 1'b0;
    #1;
    chk_reset_values("async_reset");
    @(negedge clk);
    chk("in_reset_data_en", 64'(data_en), 64'(0));
    arst_n = 1'b1;
    @(negedge clk);

    // Fresh single-word burst after reset
    wr_q.delete();
    wr_cyc_q.delete();
    pd = done_cnt;
    send(32'h0000_0600);
    send(32'd1);
    send(32'hCAFE_F00D);
    first_hs = last_hs;
    s_valid = 1'b0;
    wait_done(pd);
`ifdef DCACHE_PRELOAD_VERIFY_EN
    exp_lat = 3;
`else
    exp_lat = 2;
`endif
    chk("post_reset_done_latency", 64'(done_cyc - last_hs), 64'(exp_lat));
    chk("post_reset_err", 64'(err_at_done), 64'(0));
    chk("post_reset_write_count", 64'(wr_q.size()), 64'(1));
    if (wr_cyc_q.size() > 0)
      chk("post_reset_write_latency", 64'(wr_cyc_q[0] - first_hs), 64'(1));
    exp_q.push_back({32'h0000_0600, 32'hCAFE_F00D});
    drain_writes("post_reset_write");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dcache_preload_master.md
# dcache_preload_master

Host-side driver for the pipeline's data-memory preload port (`data_en`, `input_addr`, `input_data`, `output_check`). It accepts a valid/ready word stream (base address, word count, then data words), issues one single-cycle memory write per data word at consecutive word addresses, and reports completion to the host. With the verify feature compiled in, it reads the loaded region back through `output_check` and checks it.

## Interface
- `DPW`, 32: data and address width; matches the core datapath width.
- `CNT_W`, 8: width of the word-count field; maximum burst is 2^CNT_W − 1 words.
- `clk` input 1: core clock; all state updates on the rising edge.
- `arst_n` input 1: asynchronous, active-low reset.
- `s_valid` input 1: host stream word valid.
- `s_data` input DPW: host stream word.
- `s_ready` output 1: block accepts `s_data` this cycle.
- `data_en` output 1: memory write strobe, one cycle per word.
- `input_addr` output DPW: byte address for write or readback.
- `input_data` output DPW: write data.
- `output_check` input DPW: memory read data at `input_addr`, combinational.
- `busy` output 1: high in every state other than IDLE.
- `done` output 1: one-cycle pulse when a burst completes.
- `err` output 1: sticky verify mismatch flag; cleared when the next base word is accepted.

## Operation
- A handshake occurs when `s_valid && s_ready`.
- IDLE: `s_ready`=1.
  - Accepting a word latches `base = {s_data[DPW-1:2], 2'b00}` and clears `err`.
  - Next state: CNT.
- CNT: `s_ready`=1.
  - Accepting a word latches `n = s_data[CNT_W-1:0]`; upper bits are ignored.
  - If n==0, next state is DONE, with no writes and no verify.
  - Otherwise, next state is LOAD with index i=0.
- LOAD: `s_ready`=1.
  - Each accepted word W_i registers `data_en`=1, `input_addr` = base + 4·i, and `input_data` = W_i.
  - After the handshake for i = n−1, next state is VERIFY when compiled in, else DONE.
  - No handshake means `data_en`=0 next cycle; the host may stall indefinitely.
- VERIFY (macro only): `s_ready`=0 and `data_en`=0.
  - Drives `input_addr` = base + 4·j for j = 0..n−1, one address per cycle.
  - Accumulates the XOR of `output_check` samples. During LOAD, the XOR of all written words is accumulated.
  - After j = n−1, if the two XORs differ, `err` is set.
  - Next state: DONE.
- DONE: `done`=1 for one cycle, `s_ready`=0. Next state: IDLE.
- Address arithmetic is modulo 2^DPW; wrap past 0xFFFF_FFFC continues at 0x0000_0000 silently.
- Index and count counters are CNT_W bits and never overflow, because n ≤ 2^CNT_W − 1.

## Timing
- Reset values: `s_ready`=1 (IDLE), `data_en`=0, `input_addr`=0, `input_data`=0, `busy`=0, `done`=0, `err`=0. All internal counters and accumulators are 0.
- Reset assertion mid-burst returns the block to IDLE immediately. No partial `data_en` pulse survives, and `err` is cleared.
- `s_ready` is a pure function of state (registered), with no combinational path from `s_valid`.
- Write latency: handshake in cycle t gives `data_en` high in cycle t+1 with address and data stable.
- Back-to-back handshakes produce back-to-back writes: n words take minimum n+2 cycles from the base handshake to the last write.
- VERIFY lasts exactly n cycles. `output_check` is sampled in the same cycle as the driven `input_addr`. DONE follows in the next cycle.
- `done` rises the cycle after the last write (no verify) or the cycle after the last readback sample (verify). `busy` falls with the return to IDLE.

## Configuration
- `DCACHE_PRELOAD_VERIFY_EN` defined: VERIFY state, XOR accumulators and `err` logic are present.
- Not defined: LOAD goes directly to DONE, and `err` is tied to 0.

## Test plan
- Basic load: stream 0x100, 3, 0xAAAA0001, 0xAAAA0002, 0xAAAA0003 with `s_valid` continuous → writes at 0x100/0x104/0x108 on consecutive cycles, one `done` pulse, `err`=0.
- Misaligned base and zero count: base 0x203, count 0 → no `data_en` pulses, `done` two cycles after the count handshake. Base 0x203 with count 1 → write to 0x200.
- Host stall: count 2, with `s_valid` dropped 5 cycles between data words → exactly 2 `data_en` pulses, gap of 6 cycles, addresses consecutive.
- Address wrap: base 0xFFFFFFF8, count 4 → addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
- Verify mismatch (macro on): memory model corrupts the word at 0x104 → `input_addr` sweeps 0x100..0x108 during VERIFY, `err`=1 with `done`. The next base handshake clears `err`.
- Reset mid-burst: assert `arst_n`=0 after the 2nd of 4 data words → all outputs at reset values asynchronously. After release, a fresh 1-word burst completes normally.
